// File: rtl/nwc_pkg.sv
// nwc_pkg: shared constants, Barrett parameters and FSM states for the NWC datapath
package nwc_pkg;
  localparam int N = 4096;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam logic [31:0] Q = 32'd786433;
  localparam int BK = 40;
  localparam logic [20:0] MU = 21'((64'd1 << BK) / 64'(Q));
  localparam logic [31:0] N_INV = 32'd786241;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
endpackage

// File: rtl/nwc_modmul.sv
// nwc_modmul: pipelined (a*b) mod Q lane using Barrett reduction with valid pipe
module nwc_modmul
  import nwc_pkg::*;
#(
  parameter bit PREG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              v_in,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              v_out,
  output logic [DATA_W-1:0] r
);
  logic [BK-1:0] prod, x, x_r;
  logic [20:0] q_r;
  logic vx, vm;
  logic [DATA_W-1:0] t;
  assign prod = BK'(a) * BK'(b);
  generate
    if (PREG) begin : g_preg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          x <= '0;
          vx <= 1'b0;
        end else begin
          x <= prod;
          vx <= v_in;
        end
      end
    end else begin : g_comb
      assign x = prod;
      assign vx = v_in;
    end
  endgenerate
  // q never exceeds x/Q, so the remainder below cannot underflow and stays under 2Q
  assign t = DATA_W'(x_r - BK'(q_r) * BK'(Q));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r <= '0;
      q_r <= '0;
      vm <= 1'b0;
      v_out <= 1'b0;
      r <= '0;
    end else begin
      x_r <= x;
      q_r <= 21'(({21'd0, x} * {40'd0, MU}) >> BK);
      vm <= vx;
      v_out <= vm;
      if (vm) r <= (t >= Q) ? t - Q : t;
    end
  end
endmodule

// File: rtl/nwc_top.sv
// nwc_top: pointwise NTT-domain multiply of two up/down BRAM operands mod Q
// NWC_NINV_SCALE_EN: additionally scale each result by N^-1 mod Q (latency 6)
module nwc_top
  import nwc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addrr,
  input  logic [DATA_W-1:0] data_in0_up,
  input  logic [DATA_W-1:0] data_in0_down,
  input  logic [DATA_W-1:0] data_in1_up,
  input  logic [DATA_W-1:0] data_in1_down,
  output logic [ADDR_W-1:0] addrw,
  output logic [DATA_W-1:0] data_out_up,
  output logic [DATA_W-1:0] data_out_down,
  output logic [3:0]        out_wen,
  output logic              done,
  output logic              ready
);
`ifdef NWC_NINV_SCALE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(4 * (N / 2 - 1));
  state_t state, state_nx;
  logic [LAT-2:0] d_v;
  logic [ADDR_W-1:0] d_a [LAT-1];
  logic v_up, v_dn;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addrr <= '0;
      addrw <= '0;
      d_v <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) addrr <= '0;
      else if (state == RUN && addrr != A_LAST) addrr <= addrr + ADDR_W'(4);
      d_v <= {d_v[LAT-3:0], state == RUN};
      d_a[0] <= addrr;
      for (int k = 1; k < LAT - 1; k++) d_a[k] <= d_a[k-1];
      if (d_v[LAT-2]) addrw <= d_a[LAT-2];
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = (addrr == A_LAST) ? DRAIN : RUN;
      DRAIN:   state_nx = (d_v == '0) ? FIN : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  assign ready = state == IDLE;
  assign done = state == FIN;
  assign out_wen = {4{v_up & v_dn}};
`ifdef NWC_NINV_SCALE_EN
  logic [DATA_W-1:0] m_up, m_dn;
  logic mv_up, mv_dn;
  nwc_modmul u_up (.clk(clk), .rst_n(rst_n), .v_in(d_v[0]), .a(data_in0_up), .b(data_in1_up), .v_out(mv_up), .r(m_up));
  nwc_modmul u_dn (.clk(clk), .rst_n(rst_n), .v_in(d_v[0]), .a(data_in0_down), .b(data_in1_down), .v_out(mv_dn), .r(m_dn));
  nwc_modmul #(.PREG(1'b0)) u_sup (.clk(clk), .rst_n(rst_n), .v_in(mv_up), .a(m_up), .b(N_INV), .v_out(v_up), .r(data_out_up));
  nwc_modmul #(.PREG(1'b0)) u_sdn (.clk(clk), .rst_n(rst_n), .v_in(mv_dn), .a(m_dn), .b(N_INV), .v_out(v_dn), .r(data_out_down));
`else
  nwc_modmul u_up (.clk(clk), .rst_n(rst_n), .v_in(d_v[0]), .a(data_in0_up), .b(data_in1_up), .v_out(v_up), .r(data_out_up));
  nwc_modmul u_dn (.clk(clk), .rst_n(rst_n), .v_in(d_v[0]), .a(data_in0_down), .b(data_in1_down), .v_out(v_dn), .r(data_out_down));
`endif
endmodule

// File: tb/tb_nwc_top.sv
// tb_nwc_top: directed self-checking bench for nwc_top (NWC_NINV_SCALE_EN aware)
module tb_nwc_top;
  localparam int Q = 786433;
`ifdef NWC_NINV_SCALE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [12:0] addrr, addrw;
  logic [31:0] din0_up = '0, din0_dn = '0, din1_up = '0, din1_dn = '0;
  logic [31:0] data_out_up, data_out_down;
  logic [3:0] out_wen;
  logic done, ready;
  int mode = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] o_up [2048];
  logic [31:0] o_dn [2048];

  nwc_top dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addrr(addrr),
    .data_in0_up(din0_up), .data_in0_down(din0_dn),
    .data_in1_up(din1_up), .data_in1_down(din1_dn),
    .addrw(addrw), .data_out_up(data_out_up), .data_out_down(data_out_down),
    .out_wen(out_wen), .done(done), .ready(ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_a(input int m, input int idx);
    return m == 0 ? 32'(idx) : m == 1 ? 32'(Q - 1) : m == 2 ? 32'd0 : 32'd1;
  endfunction

  function automatic logic [31:0] mem_b(input int m, input int idx);
    return (m == 0 || m == 2) ? 32'(idx) : m == 4 ? 32'd1 : 32'(Q - 1);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = (64'(a) * 64'(b)) % 64'(Q);
`ifdef NWC_NINV_SCALE_EN
    p = (p * 64'd786241) % 64'(Q);
`endif
    return p[31:0];
  endfunction

  always @(posedge clk) begin
    din0_up <= mem_a(mode, int'(addrr >> 2));
    din0_dn <= mem_a(mode, int'(addrr >> 2) + 2048);
    din1_up <= mem_b(mode, int'(addrr >> 2));
    din1_dn <= mem_b(mode, int'(addrr >> 2) + 2048);
  end

  task automatic run_op(input int m);
    int wr, done_cyc, n_done, bad_rdy;
    logic [31:0] eu, ed;
    mode = m; wr = 0; done_cyc = 0; n_done = 0; bad_rdy = 0;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_idle mode=%0d got=%b want=1", m, ready); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 2200; cyc++) begin
      if (cyc == 1) begin
        n_chk++; if (addrr !== 13'd0) begin n_fail++; $display("FAIL first_addrr mode=%0d got=%0d want=0", m, addrr); end
      end
      if (cyc == 100) start = 1'b1;
      if (cyc == 101) start = 1'b0;
      if (done_cyc == 0 && ready !== 1'b0) bad_rdy++;
      if (out_wen === 4'hF) begin
        eu = model(mem_a(m, wr), mem_b(m, wr));
        ed = model(mem_a(m, wr + 2048), mem_b(m, wr + 2048));
        n_chk++; if (addrw !== 13'(4 * wr)) begin n_fail++; $display("FAIL addrw w=%0d got=%0d want=%0d", wr, addrw, 4 * wr); end
        n_chk++; if (cyc != wr + 1 + LAT) begin n_fail++; $display("FAIL wr_cycle w=%0d got=%0d want=%0d", wr, cyc, wr + 1 + LAT); end
        n_chk++; if (data_out_up !== eu) begin n_fail++; $display("FAIL out_up mode=%0d w=%0d got=%0d want=%0d", m, wr, data_out_up, eu); end
        n_chk++; if (data_out_down !== ed) begin n_fail++; $display("FAIL out_dn mode=%0d w=%0d got=%0d want=%0d", m, wr, data_out_down, ed); end
        if (wr < 2048) begin o_up[wr] = data_out_up; o_dn[wr] = data_out_down; end
        wr++;
      end else if (out_wen !== 4'h0) begin
        n_chk++; n_fail++; $display("FAIL out_wen cyc=%0d got=%h want=0", cyc, out_wen);
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after got=%b want=1", ready); end
        break;
      end
      @(negedge clk);
    end
    n_chk++; if (wr != 2048) begin n_fail++; $display("FAIL n_writes mode=%0d got=%0d want=2048", m, wr); end
    n_chk++; if (done_cyc != 2048 + 1 + LAT) begin n_fail++; $display("FAIL done_cycle mode=%0d got=%0d want=%0d", m, done_cyc, 2049 + LAT); end
    n_chk++; if (n_done != 1) begin n_fail++; $display("FAIL done_width mode=%0d got=%0d want=1", m, n_done); end
    n_chk++; if (bad_rdy != 0) begin n_fail++; $display("FAIL ready_busy mode=%0d got=%0d high cycles want=0", m, bad_rdy); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b want=1", ready); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b want=0", done); end
    n_chk++; if (out_wen !== 4'h0) begin n_fail++; $display("FAIL rst_wen got=%h want=0", out_wen); end
    n_chk++; if (addrr !== 13'd0 || addrw !== 13'd0) begin n_fail++; $display("FAIL rst_addr got=%0d/%0d want=0/0", addrr, addrw); end
    n_chk++; if (data_out_up !== 32'd0 || data_out_down !== 32'd0) begin n_fail++; $display("FAIL rst_data got=%0d/%0d want=0/0", data_out_up, data_out_down); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    run_op(0);
`ifdef NWC_NINV_SCALE_EN
    n_chk++; if (o_up[5] !== 32'd781633) begin n_fail++; $display("FAIL nom_up5 got=%0d want=781633", o_up[5]); end
`else
    n_chk++; if (o_up[5] !== 32'd25) begin n_fail++; $display("FAIL nom_up5 got=%0d want=25", o_up[5]); end
    n_chk++; if (o_dn[5] !== 32'd282644) begin n_fail++; $display("FAIL nom_dn5 got=%0d want=282644", o_dn[5]); end
    n_chk++; if (o_up[2047] !== 32'd258044) begin n_fail++; $display("FAIL nom_up2047 got=%0d want=258044", o_up[2047]); end
    n_chk++; if (o_dn[2047] !== 32'd253932) begin n_fail++; $display("FAIL nom_dn2047 got=%0d want=253932", o_dn[2047]); end
`endif
  endtask

  task automatic test_reset_mid();
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3000 && addrr !== 13'd4000; k++) @(negedge clk);
    n_chk++; if (addrr !== 13'd4000) begin n_fail++; $display("FAIL mid_reach got=%0d want=4000", addrr); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b want=1", ready); end
    n_chk++; if (out_wen !== 4'h0) begin n_fail++; $display("FAIL mid_wen got=%h want=0", out_wen); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got=%b want=0", done); end
    run_op(0);
  endtask

  task automatic test_boundary();
`ifdef NWC_NINV_SCALE_EN
    run_op(1);
    n_chk++; if (o_up[0] !== 32'd786241) begin n_fail++; $display("FAIL qm1_sq got=%0d want=786241", o_up[0]); end
    run_op(2);
    n_chk++; if (o_dn[9] !== 32'd0) begin n_fail++; $display("FAIL zero got=%0d want=0", o_dn[9]); end
    run_op(3);
    n_chk++; if (o_up[3] !== 32'd192) begin n_fail++; $display("FAIL one_qm1 got=%0d want=192", o_up[3]); end
    run_op(4);
    n_chk++; if (o_up[0] !== 32'd786241) begin n_fail++; $display("FAIL ninv got=%0d want=786241", o_up[0]); end
`else
    run_op(1);
    n_chk++; if (o_up[0] !== 32'd1) begin n_fail++; $display("FAIL qm1_sq got=%0d want=1", o_up[0]); end
    run_op(2);
    n_chk++; if (o_dn[9] !== 32'd0) begin n_fail++; $display("FAIL zero got=%0d want=0", o_dn[9]); end
    run_op(3);
    n_chk++; if (o_up[3] !== 32'd786432) begin n_fail++; $display("FAIL one_qm1 got=%0d want=786432", o_up[3]); end
    run_op(4);
    n_chk++; if (o_up[0] !== 32'd1) begin n_fail++; $display("FAIL one_one got=%0d want=1", o_up[0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_mid();
    test_boundary();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/nwc_top.md
Name: nwc_top

Overview:
- Negative-wrapped-convolution (NWC) datapath top for the NTT accelerator.
- Operates on two N=4096-coefficient operands already in NTT domain. Each operand is stored in two 2048-word BRAM halves: "up" holds coefficients 0..2047, "down" holds 2048..4095.
- On start, streams both operands out of BRAM and multiplies them pointwise mod Q. The result polynomial is written to an output BRAM pair with the same up/down layout.
- Sits between the forward-NTT stage and the inverse-NTT stage.

Parameters:
- N, 4096, polynomial length; each memory half holds N/2 words.
- Q, 786433, prime modulus (3·2^18+1); all coefficients are < Q.
- ADDR_W, 13, byte-address width (N/2 words × 4 bytes).
- DATA_W, 32, coefficient word width.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- start, input, 1, begin an operation; honoured only while ready=1.
- addrr, output, 13, byte read address shared by all four input halves; always a multiple of 4.
- data_in0_up, input, 32, operand A coefficient [addrr/4], valid 1 cycle after addrr.
- data_in0_down, input, 32, operand A coefficient [addrr/4 + N/2].
- data_in1_up, input, 32, operand B coefficient [addrr/4].
- data_in1_down, input, 32, operand B coefficient [addrr/4 + N/2].
- addrw, output, 13, byte write address shared by both output halves.
- data_out_up, output, 32, result coefficient [addrw/4].
- data_out_down, output, 32, result coefficient [addrw/4 + N/2].
- out_wen, output, 4, byte write enables for both output halves; 4'hF = write, 4'h0 = idle.
- done, output, 1, one-cycle pulse after the last write.
- ready, output, 1, high when idle and able to accept start.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - addrr=0, addrw=0, data_out_*=0, out_wen=0, done=0, ready=1.
  - All pipeline valid bits cleared; the FSM returns to IDLE.
  - Applies mid-operation as well; any partially written result is abandoned.
- FSM states:
  - IDLE: ready=1. On start=1, go to RUN and set ready=0 on the next edge.
  - RUN: issue one read per cycle. addrr = 4·i for i = 0..N/2-1, starting the cycle after start is sampled. After i = N/2-1 is issued, go to DRAIN.
  - DRAIN: wait until the pipeline is empty, then go to FIN.
  - FIN: done=1 for exactly one cycle, then IDLE with ready=1.
- Memory model: synchronous read. Data for address 4·i is on the data_in_* ports in the cycle after addrr=4·i.
- Datapath, two identical lanes (up and down):
  - Cycle +1: capture a and b.
  - Cycle +2: register the 64-bit product a·b.
  - Cycles +3, +4: two-stage Barrett reduction mod Q, with a final conditional subtract.
  - Output is (a·b) mod Q, zero-extended to 32 bits.
- Latency: addrw=4·i, out_wen=4'hF and valid data_out_* appear exactly 4 cycles after addrr=4·i.
  - N/2 consecutive write cycles, no bubbles.
  - out_wen=0 on every other cycle.
- Timing of done: asserted the cycle after the last write (addrw = 4·(N/2-1)).
- Total run length: from start sampled to done = N/2 + 5 cycles.
- start while ready=0 is ignored and is not queued.
- start held high continuously starts a new run on the cycle after FIN.
- addrr holds its last value while not in RUN.
- addrw and data_out_* hold their last values while out_wen=0.
- Inputs ≥ Q are outside the contract. Output is then unspecified but still a 32-bit value, with no X propagation.

Optional Feature:
- Macro: NWC_NINV_SCALE_EN.
- When defined:
  - Each lane multiplies its result by N_INV = N^-1 mod Q (constant 786241 for the defaults) through one more multiply and Barrett stage.
  - Write latency becomes 6 cycles; done still follows the last write by 1 cycle.
  - The output equals the scaled product required by the final inverse-NTT normalization.
- When undefined: no scaling, 4-cycle latency as specified above.

Decomposition:
- Package nwc_pkg holds:
  - Q, N, ADDR_W, DATA_W.
  - Barrett constants: shift k = 2·ceil(log2 Q) = 40 and mu = floor(2^k / Q).
  - N_INV.
  - The FSM state enum (IDLE, RUN, DRAIN, FIN).
- One sub-module, nwc_modmul: pipelined (a·b) mod Q lane with a valid-in/valid-out pipe. Instantiated twice (up and down), plus once more per lane under NWC_NINV_SCALE_EN.
- nwc_top contains the FSM, the address counters and the valid/address delay line.

Test Plan:
- Nominal run: rst_n low 2 cycles, then start pulse 1 cycle. Memory returns up=addrr/4, down=addrr/4+2048 for both operands.
  - At addrw=4·5: data_out_up=25, data_out_down=282644.
  - At addrw=4·2047: data_out_up=4190209-3932165=258044, data_out_down=253932.
- Latency check: addrw=0 with out_wen=4'hF exactly 4 cycles after addrr=0. Exactly 2048 write cycles, contiguous.
- Handshake: ready=0 from the cycle after start until FIN. done is high for 1 cycle, N/2+5 cycles after start is sampled. A start pulse during RUN has no effect.
- Reset mid-run: rst_n=0 at i=1000. Next cycle: ready=1, out_wen=0, done=0. A new start restarts from addrr=0.
- Boundary values: a=b=Q-1 → out=1. a=0 → out=0. a=1, b=Q-1 → out=Q-1 (786432).
- With NWC_NINV_SCALE_EN: a=b=1 → out=786241, at 6-cycle latency.
